// File: rtl/memory_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares the single RAM port between the instruction and data requests of the
// two cores. At most one request is granted at a time. Data requests always
// beat instruction requests. Contested requests of the same kind alternate
// round-robin. A cache-to-cache transfer flagged by the coherence controller
// writes the peer's dirty line back to RAM. The same data is forwarded
// straight to the reading core.
//
// Handshake (all request channels):
//   - A request line (iREN[k], dREN[k] or dWEN[k]) acts as "valid". The
//     requester holds it, together with its address and store data, until it
//     sees its wait output low.
//   - A wait output low for exactly one cycle is the "ready"/acknowledge. The
//     returned load data is valid only in that cycle.
//   - Dropping a request before the acknowledge withdraws it. Nothing is
//     acknowledged in that case.
//
// Ports:
//   CLK, nRST        clock, asynchronous active-low reset
//   iREN/iaddr       per-core instruction read request and word address
//   iwait/iload      per-core instruction wait and returned instruction
//   dREN/dWEN        per-core data read / write request
//   daddr/dstore     per-core data address and write value
//   dwait/dload      per-core data wait and returned data
//   c2c              current data read is served by the peer cache
//   ramREN/ramWEN    RAM read / write strobes
//   ramaddr/ramstore RAM address and write data
//   ramload          RAM read data
//   ramstate         RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
//   dbg_state        FSM state (0 IDLE, 1 DSERVE, 2 ISERVE)
//   dbg_owner        currently granted core
//   dbg_dprio        data round-robin pointer
//   dbg_iprio        instruction round-robin pointer
// -----------------------------------------------------------------------------
module memory_arbiter #(
  parameter int RESET_PRIORITY = 0
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] iload,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  output logic [1:0]       dwait,
  output logic [1:0][31:0] dload,
  input  logic             c2c,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate,
  output logic [1:0]       dbg_state,
  output logic             dbg_owner,
  output logic             dbg_dprio,
  output logic             dbg_iprio
);

  localparam logic       RST_PRIO   = (RESET_PRIORITY != 0);
  localparam logic [1:0] RAM_ACCESS = 2'd2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DSERVE = 2'd1,
    ISERVE = 2'd2
  } state_t;

  state_t state, next_state;
  logic   owner, next_owner;
  logic   dprio, next_dprio;
  logic   iprio, next_iprio;

  logic [1:0] d_any;
  logic       peer;
  logic       access;

  assign d_any  = dREN | dWEN;
  assign peer   = ~owner;
  assign access = (ramstate == RAM_ACCESS);

  // State register. Reset is asynchronous, so the outputs decoded from
  // state drop to idle values the moment nRST falls, even mid-transaction.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      owner <= 1'b0;
      dprio <= RST_PRIO;
      iprio <= RST_PRIO;
    end else begin
      state <= next_state;
      owner <= next_owner;
      dprio <= next_dprio;
      iprio <= next_iprio;
    end
  end

  // Next-state and output decode.
  always_comb begin
    next_state = state;
    next_owner = owner;
    next_dprio = dprio;
    next_iprio = iprio;
    iwait      = 2'b11;
    dwait      = 2'b11;
    iload      = '0;
    dload      = '0;
    ramREN     = 1'b0;
    ramWEN     = 1'b0;
    ramaddr    = '0;
    ramstore   = '0;

    case (state)
      IDLE: begin
        // Grant is registered. The winner is presented to RAM next cycle.
        // A lone requester wins outright. Both requesting defers to the
        // pointer. For a lone requester, bit 1 of the request vector is
        // exactly its core index.
        if (d_any != 2'b00) begin
          next_state = DSERVE;
          next_owner = (d_any == 2'b11) ? dprio : d_any[1];
        end else if (iREN != 2'b00) begin
          next_state = ISERVE;
          next_owner = (iREN == 2'b11) ? iprio : iREN[1];
        end
      end

      ISERVE: begin
        if (!iREN[owner]) begin
          // Withdrawn. Release the RAM without touching the pointer.
          next_state = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr[owner];
          if (access) begin
            iwait[owner] = 1'b0;
            iload[owner] = ramload;
            next_iprio   = ~owner;
            next_state   = IDLE;
          end
        end
      end

      DSERVE: begin
        if (!d_any[owner]) begin
          next_state = IDLE;
        end else if (c2c) begin
          // Peer holds the line. Its store value goes to RAM as a
          // write-back and to the reader in the same cycle. Both cores
          // are released together when the write-back lands.
          ramWEN       = 1'b1;
          ramaddr      = daddr[owner];
          ramstore     = dstore[peer];
          dload[owner] = dstore[peer];
          if (access) begin
            dwait[owner] = 1'b0;
            dwait[peer]  = 1'b0;
            next_dprio   = ~owner;
            next_state   = IDLE;
          end
        end else if (dWEN[owner]) begin
          // A write takes precedence when read and write are both raised.
          ramWEN   = 1'b1;
          ramaddr  = daddr[owner];
          ramstore = dstore[owner];
          if (access) begin
            dwait[owner] = 1'b0;
            next_dprio   = ~owner;
            next_state   = IDLE;
          end
        end else begin
          ramREN  = 1'b1;
          ramaddr = daddr[owner];
          if (access) begin
            dwait[owner] = 1'b0;
            dload[owner] = ramload;
            next_dprio   = ~owner;
            next_state   = IDLE;
          end
        end
      end

      default: begin
        next_state = IDLE;
      end
    endcase
  end

  assign dbg_state = state;
  assign dbg_owner = owner;
  assign dbg_dprio = dprio;
  assign dbg_iprio = iprio;

endmodule

// File: tb/tb_memory_arbiter.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_memory_arbiter
//
// Directed scenarios for latency, contention, priority, cache-to-cache,
// withdrawal and reset. A randomized phase follows. In each round it raises a
// random set of requests and predicts the grant order from the arbitration
// rules. It predicts when each serve starts and acknowledges. Returned data
// is predicted from a memory model.
// -----------------------------------------------------------------------------
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [1:0]       iREN, iwait, dREN, dWEN, dwait, ramstate, dbg_state;
  logic [1:0][31:0] iaddr, iload, daddr, dstore, dload;
  logic             c2c, ramREN, ramWEN, dbg_owner, dbg_dprio, dbg_iprio;
  logic [31:0]      ramaddr, ramstore, ramload;

  int n_checks = 0;
  int n_fail   = 0;

  // RAM contents seen by the randomized phase.
  logic [31:0] mem [logic [31:0]];

  memory_arbiter #(.RESET_PRIORITY(0)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload), .c2c(c2c),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
    .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
    .dbg_state(dbg_state), .dbg_owner(dbg_owner),
    .dbg_dprio(dbg_dprio), .dbg_iprio(dbg_iprio)
  );

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic idle_inputs();
    iREN = '0; dREN = '0; dWEN = '0; c2c = 1'b0;
    iaddr = '0; daddr = '0; dstore = '0;
    ramstate = FREE; ramload = '0;
  endtask

  // Leaves the caller at a falling edge with reset released.
  task automatic do_reset();
    @(negedge CLK);
    nRST = 1'b0;
    idle_inputs();
    repeat (2) @(negedge CLK);
    nRST = 1'b1;
  endtask

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_5A5A;
  endfunction

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    #1;
    n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL rst_iwait: got %b expected 11", iwait); end
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL rst_dwait: got %b expected 11", dwait); end
    n_checks++; if (iload !== 64'h0) begin n_fail++; $display("FAIL rst_iload: got %h expected 0", iload); end
    n_checks++; if (dload !== 64'h0) begin n_fail++; $display("FAIL rst_dload: got %h expected 0", dload); end
    n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes: got %b expected 00", {ramREN, ramWEN}); end
    n_checks++; if (ramaddr !== 32'h0) begin n_fail++; $display("FAIL rst_ramaddr: got %h expected 0", ramaddr); end
    n_checks++; if (ramstore !== 32'h0) begin n_fail++; $display("FAIL rst_ramstore: got %h expected 0", ramstore); end
  endtask

  // Core0 read, two BUSY cycles then ACCESS. Cycle 1 is the request cycle.
  task automatic test_read_latency();
    logic [1:0]  exp_w;
    logic [31:0] exp_d;
    @(negedge CLK);
    dREN[0] = 1'b1; daddr[0] = 32'h100; ramstate = BUSY;
    #1;
    n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL lat_c1_ramREN: got %b expected 0", ramREN); end
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL lat_c1_dwait: got %b expected 11", dwait); end
    for (int c = 2; c <= 4; c++) begin
      @(negedge CLK);
      ramstate = (c == 4) ? ACCESS : BUSY;
      ramload  = 32'hDEAD_BEEF;
      #1;
      exp_w = (c == 4) ? 2'b10 : 2'b11;
      exp_d = (c == 4) ? 32'hDEAD_BEEF : 32'h0;
      n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL lat_c%0d_ramREN: got %b expected 1", c, ramREN); end
      n_checks++; if (ramaddr !== 32'h100) begin n_fail++; $display("FAIL lat_c%0d_ramaddr: got %h expected 100", c, ramaddr); end
      n_checks++; if (dwait !== exp_w) begin n_fail++; $display("FAIL lat_c%0d_dwait: got %b expected %b", c, dwait, exp_w); end
      n_checks++; if (dload[0] !== exp_d) begin n_fail++; $display("FAIL lat_c%0d_dload: got %h expected %h", c, dload[0], exp_d); end
    end
    @(negedge CLK);
    dREN = '0; ramstate = FREE;
    #1;
    n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL lat_c5_ramREN: got %b expected 0", ramREN); end
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL lat_c5_dwait: got %b expected 11", dwait); end
  endtask

  task automatic test_contested_write();
    do_reset();
    @(negedge CLK);
    dWEN = 2'b11; ramstate = ACCESS;
    daddr[0] = 32'h0A0; dstore[0] = 32'h0000_AAAA;
    daddr[1] = 32'h0B0; dstore[1] = 32'h0000_BBBB;
    #1;
    n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL cw_idle_ramWEN: got %b expected 0", ramWEN); end
    @(negedge CLK); #1;
    n_checks++; if (ramWEN !== 1'b1) begin n_fail++; $display("FAIL cw_first_ramWEN: got %b expected 1", ramWEN); end
    n_checks++; if (ramaddr !== 32'h0A0) begin n_fail++; $display("FAIL cw_first_addr: got %h expected 0a0", ramaddr); end
    n_checks++; if (ramstore !== 32'h0000_AAAA) begin n_fail++; $display("FAIL cw_first_store: got %h expected aaaa", ramstore); end
    n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL cw_first_ack: got %b expected 10", dwait); end
    @(negedge CLK);
    dWEN[0] = 1'b0;
    #1;
    n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL cw_gap_ramWEN: got %b expected 0", ramWEN); end
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL cw_gap_dwait: got %b expected 11", dwait); end
    @(negedge CLK); #1;
    n_checks++; if (ramaddr !== 32'h0B0) begin n_fail++; $display("FAIL cw_second_addr: got %h expected 0b0", ramaddr); end
    n_checks++; if (ramstore !== 32'h0000_BBBB) begin n_fail++; $display("FAIL cw_second_store: got %h expected bbbb", ramstore); end
    n_checks++; if (dwait !== 2'b01) begin n_fail++; $display("FAIL cw_second_ack: got %b expected 01", dwait); end
    @(negedge CLK);
    dWEN = 2'b11;
    #1;
    n_checks++; if (ramWEN !== 1'b0) begin n_fail++; $display("FAIL cw_gap2_ramWEN: got %b expected 0", ramWEN); end
    @(negedge CLK); #1;
    n_checks++; if (ramaddr !== 32'h0A0) begin n_fail++; $display("FAIL cw_third_addr: got %h expected 0a0", ramaddr); end
    n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL cw_third_ack: got %b expected 10", dwait); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_data_beats_instr();
    @(negedge CLK);
    iREN[0] = 1'b1; iaddr[0] = 32'h40;
    dREN[1] = 1'b1; daddr[1] = 32'h300; ramstate = BUSY;
    #1;
    n_checks++; if ({iwait, dwait} !== 4'b1111) begin n_fail++; $display("FAIL dbi_idle_waits: got %b expected 1111", {iwait, dwait}); end
    @(negedge CLK);
    ramload = 32'h1111_2222;
    #1;
    n_checks++; if (ramaddr !== 32'h300) begin n_fail++; $display("FAIL dbi_data_addr: got %h expected 300", ramaddr); end
    n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL dbi_busy_iwait: got %b expected 11", iwait); end
    @(negedge CLK);
    ramstate = ACCESS;
    #1;
    n_checks++; if (dwait !== 2'b01) begin n_fail++; $display("FAIL dbi_data_ack: got %b expected 01", dwait); end
    n_checks++; if (dload[1] !== 32'h1111_2222) begin n_fail++; $display("FAIL dbi_dload: got %h expected 11112222", dload[1]); end
    n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL dbi_ack_iwait: got %b expected 11", iwait); end
    @(negedge CLK);
    dREN[1] = 1'b0; ramload = 32'hCAFE_F00D;
    #1;
    n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL dbi_gap_ramREN: got %b expected 0", ramREN); end
    n_checks++; if (iwait !== 2'b11) begin n_fail++; $display("FAIL dbi_gap_iwait: got %b expected 11", iwait); end
    @(negedge CLK); #1;
    n_checks++; if (ramaddr !== 32'h40) begin n_fail++; $display("FAIL dbi_instr_addr: got %h expected 40", ramaddr); end
    n_checks++; if (iwait !== 2'b10) begin n_fail++; $display("FAIL dbi_instr_ack: got %b expected 10", iwait); end
    n_checks++; if (iload[0] !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL dbi_iload: got %h expected cafef00d", iload[0]); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_c2c();
    @(negedge CLK);
    dREN[0] = 1'b1; daddr[0] = 32'h200; c2c = 1'b1;
    dstore[0] = 32'h0BAD_0BAD; dstore[1] = 32'h1234_5678;
    ramstate = BUSY; ramload = 32'hFFFF_0000;
    @(negedge CLK); #1;
    n_checks++; if ({ramREN, ramWEN} !== 2'b01) begin n_fail++; $display("FAIL c2c_strobes: got %b expected 01", {ramREN, ramWEN}); end
    n_checks++; if (ramaddr !== 32'h200) begin n_fail++; $display("FAIL c2c_addr: got %h expected 200", ramaddr); end
    n_checks++; if (ramstore !== 32'h1234_5678) begin n_fail++; $display("FAIL c2c_store: got %h expected 12345678", ramstore); end
    n_checks++; if (dload[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL c2c_fwd_busy: got %h expected 12345678", dload[0]); end
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL c2c_busy_dwait: got %b expected 11", dwait); end
    @(negedge CLK);
    ramstate = ACCESS;
    #1;
    n_checks++; if (dwait !== 2'b00) begin n_fail++; $display("FAIL c2c_ack: got %b expected 00", dwait); end
    n_checks++; if (dload[0] !== 32'h1234_5678) begin n_fail++; $display("FAIL c2c_fwd_ack: got %h expected 12345678", dload[0]); end
    @(negedge CLK);
    idle_inputs();
    #1;
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL c2c_after: got %b expected 11", dwait); end
  endtask

  // The pointer is first moved to core1 by a core0 ack. It must still favour
  // core1 after core1 withdraws.
  task automatic test_withdraw();
    do_reset();
    @(negedge CLK);
    dREN[0] = 1'b1; daddr[0] = 32'h10; ramstate = ACCESS; ramload = 32'h1;
    @(negedge CLK); #1;
    n_checks++; if (dwait !== 2'b10) begin n_fail++; $display("FAIL wd_pre_ack: got %b expected 10", dwait); end
    @(negedge CLK);
    dREN = 2'b10; daddr[1] = 32'h20; ramstate = BUSY;
    @(negedge CLK); #1;
    n_checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h20) begin n_fail++; $display("FAIL wd_serve: got %b/%h expected 1/20", ramREN, ramaddr); end
    @(negedge CLK);
    dREN[1] = 1'b0;
    #1;
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL wd_no_ack: got %b expected 11", dwait); end
    @(negedge CLK);
    dREN = 2'b11; daddr[0] = 32'h30; ramstate = ACCESS;
    #1;
    n_checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin n_fail++; $display("FAIL wd_idle_next: got %b/%b expected 0/11", ramREN, dwait); end
    @(negedge CLK); #1;
    n_checks++; if (ramaddr !== 32'h20) begin n_fail++; $display("FAIL wd_prio_kept_addr: got %h expected 20", ramaddr); end
    n_checks++; if (dwait !== 2'b01) begin n_fail++; $display("FAIL wd_prio_kept_ack: got %b expected 01", dwait); end
    @(negedge CLK);
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    dREN[0] = 1'b1; daddr[0] = 32'h400; ramstate = BUSY;
    @(negedge CLK); #1;
    n_checks++; if (ramREN !== 1'b1) begin n_fail++; $display("FAIL rm_serve: got %b expected 1", ramREN); end
    #2;
    nRST = 1'b0;
    #1;
    n_checks++; if (ramREN !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop: got %b expected 0", ramREN); end
    n_checks++; if (dwait !== 2'b11) begin n_fail++; $display("FAIL rm_async_dwait: got %b expected 11", dwait); end
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1; ramstate = ACCESS;
    #1;
    n_checks++; if (ramREN !== 1'b0 || dwait !== 2'b11) begin n_fail++; $display("FAIL rm_idle_after: got %b/%b expected 0/11", ramREN, dwait); end
    @(negedge CLK); #1;
    n_checks++; if (ramREN !== 1'b1 || dwait !== 2'b10) begin n_fail++; $display("FAIL rm_resume: got %b/%b expected 1/10", ramREN, dwait); end
    @(negedge CLK);
    idle_inputs();
  endtask

  // Randomized rounds. The grant order, serve timing and returned data are
  // all predicted from the arbitration rules and the memory model.
  task automatic test_random();
    logic [1:0]       exp_q[$];
    logic [1:0]       ireq, dreq, dwr, pd, pi, id, drop_id;
    logic [1:0][31:0] ia, da, ds;
    logic             dp, ip, k, in_txn, drop_valid;
    logic [3:0]       sel, acks, exp_acks;
    int               cyc, next_start, busy_left;
    do_reset();
    dp = 1'b0; ip = 1'b0;
    for (int r = 0; r < 40; r++) begin
      sel  = 4'($urandom_range(1, 15));
      ireq = sel[3:2];
      dreq = sel[1:0];
      for (int c = 0; c < 2; c++) begin
        ia[c]  = 32'($urandom_range(0, 15)) << 2;
        da[c]  = 32'($urandom_range(0, 15)) << 2;
        ds[c]  = $urandom;
        dwr[c] = 1'($urandom_range(0, 1));
      end
      // Predicted order: data before instructions, contested picks follow a
      // pointer that moves to the other core after every acknowledge.
      exp_q.delete();
      pd = dreq; pi = ireq;
      while (pd != 2'b00 || pi != 2'b00) begin
        if (pd != 2'b00) begin
          k = (pd == 2'b11) ? dp : pd[1];
          exp_q.push_back({1'b0, k}); pd[k] = 1'b0; dp = ~k;
        end else begin
          k = (pi == 2'b11) ? ip : pi[1];
          exp_q.push_back({1'b1, k}); pi[k] = 1'b0; ip = ~k;
        end
      end

      @(negedge CLK);
      iREN = ireq; iaddr = ia; daddr = da; dstore = ds; ramstate = FREE;
      for (int c = 0; c < 2; c++) begin
        dWEN[c] = dreq[c] & dwr[c];
        dREN[c] = dreq[c] & (~dwr[c] | 1'($urandom_range(0, 1)));
      end
      #1;
      n_checks++; if ({ramREN, ramWEN} !== 2'b00) begin n_fail++; $display("FAIL rnd_idle_strobes r%0d: got %b expected 00", r, {ramREN, ramWEN}); end

      cyc = 0; next_start = 1; in_txn = 1'b0; drop_valid = 1'b0; busy_left = 0;
      while (exp_q.size() != 0 && cyc < 60) begin
        @(negedge CLK);
        cyc++;
        if (drop_valid) begin
          if (drop_id[1]) iREN[drop_id[0]] = 1'b0;
          else begin dREN[drop_id[0]] = 1'b0; dWEN[drop_id[0]] = 1'b0; end
          drop_valid = 1'b0;
        end
        #1;
        if (ramREN || ramWEN) begin
          if (!in_txn) begin
            in_txn = 1'b1;
            busy_left = $urandom_range(0, 3);
            n_checks++; if (cyc !== next_start) begin n_fail++; $display("FAIL rnd_serve_start r%0d: got cycle %0d expected %0d", r, cyc, next_start); end
          end
          if (busy_left > 0) begin
            ramstate = ($urandom_range(0, 1) != 0) ? BUSY : ERROR;
            busy_left--;
          end else begin
            ramstate = ACCESS;
          end
          ramload = mem_read(ramaddr);
        end else begin
          ramstate = ($urandom_range(0, 1) != 0) ? FREE : ERROR;
          ramload  = $urandom;
        end
        #1;
        acks = {~iwait, ~dwait};
        if (in_txn && ramstate == ACCESS) begin
          id = exp_q.pop_front();
          k  = id[0];
          exp_acks = id[1] ? (4'b0100 << k) : (4'b0001 << k);
          n_checks++; if (acks !== exp_acks) begin n_fail++; $display("FAIL rnd_ack r%0d: got %b expected %b", r, acks, exp_acks); end
          if (id[1]) begin
            n_checks++; if (iload[k] !== mem_read(ia[k])) begin n_fail++; $display("FAIL rnd_iload r%0d: got %h expected %h", r, iload[k], mem_read(ia[k])); end
          end else if (dwr[k]) begin
            n_checks++; if ({ramWEN, ramaddr, ramstore} !== {1'b1, da[k], ds[k]}) begin n_fail++; $display("FAIL rnd_write r%0d: got %b/%h/%h expected 1/%h/%h", r, ramWEN, ramaddr, ramstore, da[k], ds[k]); end
            mem[da[k]] = ds[k];
          end else begin
            n_checks++; if (dload[k] !== mem_read(da[k])) begin n_fail++; $display("FAIL rnd_dload r%0d: got %h expected %h", r, dload[k], mem_read(da[k])); end
          end
          in_txn = 1'b0; next_start = cyc + 2; drop_id = id; drop_valid = 1'b1;
        end else begin
          n_checks++; if (acks !== 4'b0000) begin n_fail++; $display("FAIL rnd_spurious_ack r%0d: got %b expected 0000", r, acks); end
        end
      end
      if (exp_q.size() != 0) begin
        n_checks++; n_fail++;
        $display("FAIL rnd_timeout r%0d: got %0d pending expected 0", r, exp_q.size());
        do_reset();
        dp = 1'b0; ip = 1'b0;
      end else begin
        @(negedge CLK);
        idle_inputs();
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    nRST = 1'b0;
    idle_inputs();
    test_reset();
    test_read_latency();
    test_contested_write();
    test_data_beats_instr();
    test_c2c();
    test_withdraw();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
